// File: rtl/sonic_rx_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sonic_rx_dma_pkg
// Description : Shared types and helpers for the RX ring read-side DMA
//               scheduler: FSM state encoding, default geometry constants and
//               the modular ring-occupancy helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sonic_rx_dma_pkg;

  // Default ring geometry (word address width, pointers carry one extra wrap bit)
  localparam int unsigned DEF_ADDR_WIDTH     = 13;
  localparam int unsigned DEF_BURST_WORDS    = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_IRQ_COALESCE   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // Words available in the ring: (wptr - rptr) modulo 2^ptr_w.
  // Pointers are passed zero-extended to 32 bits; the caller truncates back.
  function automatic logic [31:0] ring_avail(input logic [31:0] wptr,
                                             input logic [31:0] rptr,
                                             input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (ptr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ptr_w) - 32'd1);
    return (wptr - rptr) & mask;
  endfunction

endpackage : sonic_rx_dma_pkg
`default_nettype wire

// File: rtl/sonic_irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module      : sonic_irq_coalescer
// Description : Counts completed DMA bursts and raises a one-cycle interrupt
//               every IRQ_COALESCE bursts, or immediately for a short
//               (timeout) burst. Either event clears the count.
// Ports       : clock       - DMA clock
//               reset_n     - asynchronous active-low reset
//               burst_end_i - one-cycle strobe, one cycle before burst done
//               short_i     - the ending burst was a timeout burst
//               irq_o       - registered interrupt pulse (aligned with done)
// Revision    : 1.0 - initial release
// ============================================================================
module sonic_irq_coalescer #(
  parameter int unsigned IRQ_COALESCE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic burst_end_i,
  input  logic short_i,
  output logic irq_o
);

  localparam int unsigned CNT_W = (IRQ_COALESCE > 1) ? $clog2(IRQ_COALESCE) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(IRQ_COALESCE - 1);

  logic [CNT_W-1:0] count_q;
  logic             irq_q;

  // The strobe arrives in the DRAIN cycle so the registered pulse lands in
  // the same cycle as the scheduler's dma_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (burst_end_i) begin
        if (short_i || (count_q == C_LAST)) begin
          irq_q   <= 1'b1;
          count_q <= '0;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign irq_o = irq_q;

endmodule : sonic_irq_coalescer
`default_nettype wire

// File: rtl/sonic_rx_dma_sched.sv
`default_nettype none
// ============================================================================
// Module      : sonic_rx_dma_sched
// Description : Read-side scheduler for the RX circular buffer. Starts a DMA
//               burst on a full burst of data or after an idle timeout with
//               partial data, drives the buffer read port under sink
//               backpressure and raises coalesced interrupts.
// Ports       : clock/reset_n   - DMA clock, async active-low reset
//               enable          - port enabled
//               rx_ring_wptr    - clock-crossed ring write pointer
//               rd_address/rdreq- buffer read port
//               dma_req/dma_len - burst request and length (until dma_gnt)
//               dma_gnt         - single-cycle grant
//               dma_ready       - sink accepts a word next cycle
//               dma_valid       - buffer data_out valid (rdreq delayed by 1)
//               dma_done        - one-cycle burst-complete pulse
//               rx_ring_rptr    - current read pointer
//               irq             - coalesced interrupt pulse
//               overflow        - sticky writer-lapped-reader flag
// Revision    : 1.0 - initial release
// ============================================================================
module sonic_rx_dma_sched
  import sonic_rx_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned BURST_WORDS    = DEF_BURST_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned IRQ_COALESCE   = DEF_IRQ_COALESCE
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [ADDR_WIDTH:0]           rx_ring_wptr,
  output logic [ADDR_WIDTH-1:0]         rd_address,
  output logic                          rdreq,
  output logic                          dma_req,
  output logic [$clog2(BURST_WORDS):0]  dma_len,
  input  logic                          dma_gnt,
  input  logic                          dma_ready,
  output logic                          dma_valid,
  output logic                          dma_done,
  output logic [ADDR_WIDTH:0]           rx_ring_rptr,
  output logic                          irq,
  output logic                          overflow
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W = $clog2(BURST_WORDS) + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0] C_BURST_AV  = PTR_W'(BURST_WORDS);
  localparam logic [PTR_W-1:0] C_RING_SIZE = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LEN_W-1:0] C_BURST_LEN = LEN_W'(BURST_WORDS);
  localparam logic [TMR_W-1:0] C_TIMEOUT   = TMR_W'(TIMEOUT_CYCLES);

  sched_state_t     state_q;
  logic [PTR_W-1:0] rptr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [TMR_W-1:0] timer_q;
  logic [LEN_W-1:0] dma_len_q;
  logic             dma_req_q;
  logic             short_q;
  logic             dma_valid_q;
  logic             dma_done_q;
  logic             overflow_q;

  logic [PTR_W-1:0] w_avail;
  logic             w_ovf_now;
  logic             w_blocked;
  logic             w_rdreq;
  logic             w_burst_end;
  logic             w_irq;

  assign w_avail   = PTR_W'(ring_avail(32'(rx_ring_wptr), 32'(rptr_q), PTR_W));
  assign w_ovf_now = (w_avail > C_RING_SIZE);
  // A lap seen this very cycle must already block a start, not just the flag
  assign w_blocked = overflow_q | w_ovf_now;
  // Read strobe follows the sink's ready directly so a stalled cycle issues nothing
  assign w_rdreq   = (state_q == ST_XFER) && dma_ready;
  assign w_burst_end = (state_q == ST_DRAIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rptr_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      dma_len_q   <= '0;
      dma_req_q   <= 1'b0;
      short_q     <= 1'b0;
      dma_valid_q <= 1'b0;
      dma_done_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      dma_valid_q <= w_rdreq;
      dma_done_q  <= 1'b0;
      // Sticky; only the disabled-IDLE branch below can clear it
      if (w_ovf_now) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (!enable) begin
            // Disabled port: discard everything written so far
            rptr_q     <= rx_ring_wptr;
            overflow_q <= 1'b0;
            timer_q    <= '0;
          end else if (w_blocked) begin
            timer_q <= '0;
          end else if (w_avail >= C_BURST_AV) begin
            state_q   <= ST_REQ;
            dma_req_q <= 1'b1;
            dma_len_q <= C_BURST_LEN;
            short_q   <= 1'b0;
            timer_q   <= '0;
          end else if (w_avail == '0) begin
            timer_q <= '0;
          end else if (timer_q == C_TIMEOUT) begin
            // Partial data has waited long enough; avail < BURST fits dma_len
            state_q   <= ST_REQ;
            dma_req_q <= 1'b1;
            dma_len_q <= LEN_W'(w_avail);
            short_q   <= 1'b1;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_REQ: begin
          if (dma_gnt) begin
            state_q   <= ST_XFER;
            dma_req_q <= 1'b0;
            cnt_q     <= dma_len_q;
          end
        end

        ST_XFER: begin
          if (dma_ready) begin
            rptr_q <= rptr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          state_q    <= ST_DONE;
          dma_done_q <= 1'b1;
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sonic_irq_coalescer #(
    .IRQ_COALESCE (IRQ_COALESCE)
  ) u_irq_coalescer (
    .clock       (clock),
    .reset_n     (reset_n),
    .burst_end_i (w_burst_end),
    .short_i     (short_q),
    .irq_o       (w_irq)
  );

  assign rd_address   = rptr_q[ADDR_WIDTH-1:0];
  assign rdreq        = w_rdreq;
  assign dma_req      = dma_req_q;
  assign dma_len      = dma_len_q;
  assign dma_valid    = dma_valid_q;
  assign dma_done     = dma_done_q;
  assign rx_ring_rptr = rptr_q;
  assign irq          = w_irq;
  assign overflow     = overflow_q;

endmodule : sonic_rx_dma_sched
`default_nettype wire

// File: tb/tb_sonic_rx_dma_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sonic_rx_dma_sched
// Description : Self-checking bench for sonic_rx_dma_sched. A burst-level
//               model turns each write-pointer advance into expected requests,
//               read addresses and interrupt flags; a monitor checks the DUT
//               against those queues as it emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sonic_rx_dma_sched;

  localparam int AW = 13;
  localparam int PW = 14;
  localparam int BW = 32;
  localparam int TO = 1024;
  localparam int IC = 4;
  localparam int unsigned PMASK = 32'h3FFF;
  localparam int unsigned AMASK = 32'h1FFF;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic [PW-1:0] rx_ring_wptr;
  logic [AW-1:0] rd_address;
  logic          rdreq;
  logic          dma_req;
  logic [5:0]    dma_len;
  logic          dma_gnt;
  logic          dma_ready;
  logic          dma_valid;
  logic          dma_done;
  logic [PW-1:0] rx_ring_rptr;
  logic          irq;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  int unsigned exp_len[$];
  int unsigned exp_addr[$];
  bit          exp_irq[$];

  int unsigned m_wptr = 0;
  int unsigned m_rptr = 0;
  int unsigned m_cnt  = 0;
  int          ready_mode = 0;
  int          gnt_delay  = 2;

  sonic_rx_dma_sched #(
    .ADDR_WIDTH     (AW),
    .BURST_WORDS    (BW),
    .TIMEOUT_CYCLES (TO),
    .IRQ_COALESCE   (IC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .rx_ring_wptr (rx_ring_wptr),
    .rd_address   (rd_address),
    .rdreq        (rdreq),
    .dma_req      (dma_req),
    .dma_len      (dma_len),
    .dma_gnt      (dma_gnt),
    .dma_ready    (dma_ready),
    .dma_valid    (dma_valid),
    .dma_done     (dma_done),
    .rx_ring_rptr (rx_ring_rptr),
    .irq          (irq),
    .overflow     (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One burst of len words from the model read pointer
  task automatic push_burst(input int unsigned len, input bit is_short);
    bit irq_exp;
    exp_len.push_back(len);
    for (int i = 0; i < int'(len); i++) exp_addr.push_back((m_rptr + i) & AMASK);
    m_rptr = (m_rptr + len) & PMASK;
    m_cnt++;
    irq_exp = is_short || (m_cnt == IC);
    if (irq_exp) m_cnt = 0;
    exp_irq.push_back(irq_exp);
  endtask

  // Writer adds k words: as many full bursts as fit, then a timeout burst for the rest
  task automatic model_write(input int unsigned k);
    int unsigned avail;
    m_wptr = (m_wptr + k) & PMASK;
    avail  = (m_wptr - m_rptr) & PMASK;
    while (avail >= BW) begin
      push_burst(BW, 1'b0);
      avail -= BW;
    end
    if (avail > 0) push_burst(avail, 1'b1);
  endtask

  task automatic flush_model();
    exp_len.delete();
    exp_addr.delete();
    exp_irq.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_irq.size() != 0 || exp_addr.size() != 0 || exp_len.size() != 0) && n < 20000) begin
      @(posedge clock);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d bursts still outstanding, expected 0", name, exp_irq.size());
      flush_model();
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_rdreq(input string name);
    int n = 0;
    while (!rdreq && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_no_rdreq: rdreq=%0b, expected 1", name, rdreq);
    end
  endtask

  // DMA engine: grants after a short delay, drives the sink ready pattern
  initial begin
    int age = 0;
    dma_gnt   = 1'b0;
    dma_ready = 1'b1;
    forever begin
      @(negedge clock);
      dma_gnt = 1'b0;
      case (ready_mode)
        0:       dma_ready = 1'b1;
        1:       dma_ready = ~dma_ready;
        default: dma_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset_n && dma_req) begin
        age++;
        if (age >= gnt_delay) begin
          dma_gnt   = 1'b1;
          age       = 0;
          gnt_delay = int'($urandom_range(1, 3));
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_req  = 1'b0;
    bit          exp_valid = 1'b0;
    int unsigned cur_len   = 0;
    int unsigned n_val     = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        prev_req  = 1'b0;
        exp_valid = 1'b0;
        n_val     = 0;
        continue;
      end
      if (dma_req && !prev_req) begin
        if (exp_len.size() == 0) chk("unexpected_dma_req", 64'(dma_req), 64'(0));
        else begin
          cur_len = exp_len.pop_front();
          chk("dma_len", 64'(dma_len), 64'(cur_len));
        end
      end else if (dma_req) begin
        chk("dma_len_held", 64'(dma_len), 64'(cur_len));
      end
      prev_req = dma_req;

      if (dma_valid || exp_valid) chk("dma_valid_lag", 64'(dma_valid), 64'(exp_valid));
      if (dma_valid) n_val++;
      exp_valid = 1'b0;

      if (rdreq) begin
        if (exp_addr.size() == 0) chk("unexpected_rdreq", 64'(rdreq), 64'(0));
        else begin
          chk("rd_address", 64'(rd_address), 64'(exp_addr.pop_front()));
          exp_valid = 1'b1;
        end
      end

      if (dma_done) begin
        if (exp_irq.size() == 0) chk("unexpected_dma_done", 64'(dma_done), 64'(0));
        else begin
          chk("irq_at_done", 64'(irq), 64'(exp_irq.pop_front()));
          chk("valid_count", 64'(n_val), 64'(cur_len));
        end
        n_val = 0;
      end else if (irq) begin
        chk("irq_without_done", 64'(irq), 64'(0));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    enable       = 1'b0;
    rx_ring_wptr = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_address", 64'(rd_address), 64'(0));
    chk("rst_rdreq", 64'(rdreq), 64'(0));
    chk("rst_dma_req", 64'(dma_req), 64'(0));
    chk("rst_dma_len", 64'(dma_len), 64'(0));
    chk("rst_dma_valid", 64'(dma_valid), 64'(0));
    chk("rst_dma_done", 64'(dma_done), 64'(0));
    chk("rst_rptr", 64'(rx_ring_rptr), 64'(0));
    chk("rst_irq", 64'(irq), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    reset_n = 1'b1;
    enable  = 1'b1;
    @(posedge clock);
    #1;

    // Single full burst
    model_write(32);
    rx_ring_wptr = 14'(m_wptr);
    wait_idle("full");
    chk("rptr_full", 64'(rx_ring_rptr), 64'(m_rptr));

    // Back-to-back full bursts exercise coalescing
    model_write(128);
    rx_ring_wptr = 14'(m_wptr);
    wait_idle("coalesce");
    chk("rptr_coalesce", 64'(rx_ring_rptr), 64'(m_rptr));

    // Partial data forces a timeout burst
    model_write(5);
    rx_ring_wptr = 14'(m_wptr);
    n = 0;
    while (!dma_req && n < 1200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(TO + 1));
    wait_idle("timeout");
    chk("rptr_timeout", 64'(rx_ring_rptr), 64'(m_rptr));

    // Address wrap through the end of the ring
    enable       = 1'b0;
    m_wptr       = 32'h1FF0;
    rx_ring_wptr = 14'(m_wptr);
    repeat (2) @(posedge clock);
    #1;
    chk("rptr_snap_wrap", 64'(rx_ring_rptr), 64'(32'h1FF0));
    m_rptr = m_wptr;
    model_write(32'h20);
    rx_ring_wptr = 14'(m_wptr);
    enable       = 1'b1;
    wait_idle("wrap");
    chk("rptr_wrap", 64'(rx_ring_rptr), 64'(32'h2010));

    // Backpressure: alternating, then random ready
    ready_mode = 1;
    model_write(32);
    rx_ring_wptr = 14'(m_wptr);
    wait_idle("bp_toggle");
    ready_mode = 2;
    model_write(45);
    rx_ring_wptr = 14'(m_wptr);
    wait_idle("bp_random");
    chk("rptr_bp", 64'(rx_ring_rptr), 64'(m_rptr));
    ready_mode = 0;

    // Enable dropped mid-burst: burst completes, then pointer snaps to writer
    model_write(32);
    rx_ring_wptr = 14'(m_wptr);
    wait_rdreq("en_drop");
    enable       = 1'b0;
    m_wptr       = (m_wptr + 7) & PMASK;
    rx_ring_wptr = 14'(m_wptr);
    wait_idle("en_drop");
    chk("rptr_en_drop_snap", 64'(rx_ring_rptr), 64'(m_wptr));
    m_rptr = m_wptr;
    enable = 1'b1;

    // Randomized advances
    for (int it = 0; it < 4; it++) begin
      ready_mode = int'($urandom_range(0, 2));
      model_write($urandom_range(1, 80));
      rx_ring_wptr = 14'(m_wptr);
      wait_idle("random");
      chk("rptr_random", 64'(rx_ring_rptr), 64'(m_rptr));
    end
    ready_mode = 0;

    // Writer laps the reader
    m_wptr       = (m_rptr + 32'h2001) & PMASK;
    rx_ring_wptr = 14'(m_wptr);
    repeat (2) @(posedge clock);
    #1;
    chk("overflow_set", 64'(overflow), 64'(1));
    repeat (40) @(posedge clock);
    #1;
    chk("overflow_no_req", 64'(dma_req), 64'(0));
    chk("overflow_sticky", 64'(overflow), 64'(1));
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("overflow_cleared", 64'(overflow), 64'(0));
    chk("rptr_overflow_snap", 64'(rx_ring_rptr), 64'(m_wptr));
    m_rptr = m_wptr;
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Asynchronous reset in the middle of a transfer
    model_write(32);
    rx_ring_wptr = 14'(m_wptr);
    wait_rdreq("reset");
    reset_n = 1'b0;
    #1;
    chk("arst_rd_address", 64'(rd_address), 64'(0));
    chk("arst_rdreq", 64'(rdreq), 64'(0));
    chk("arst_dma_req", 64'(dma_req), 64'(0));
    chk("arst_dma_len", 64'(dma_len), 64'(0));
    chk("arst_dma_valid", 64'(dma_valid), 64'(0));
    chk("arst_dma_done", 64'(dma_done), 64'(0));
    chk("arst_rptr", 64'(rx_ring_rptr), 64'(0));
    chk("arst_irq", 64'(irq), 64'(0));
    chk("arst_overflow", 64'(overflow), 64'(0));
    flush_model();
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rptr_after_reset", 64'(rx_ring_rptr), 64'(m_wptr));
    m_rptr = m_wptr;
    m_cnt  = 0;
    enable = 1'b1;
    model_write(32);
    rx_ring_wptr = 14'(m_wptr);
    wait_idle("post_reset");
    chk("rptr_post_reset", 64'(rx_ring_rptr), 64'(m_rptr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sonic_rx_dma_sched
`default_nettype wire

// File: doc/sonic_rx_dma_sched.md
# sonic_rx_dma_sched

Read-side scheduler for the 66-bit RX circular buffer. It compares the exported ring write pointer with its own read pointer and decides when to start a DMA burst: on a full burst, or on a timeout for a partial one. It then drives the buffer's `rd_address`/`rdreq` port under sink backpressure and raises coalesced interrupts. It sits in the PCIe/DMA clock domain, between the RX buffer's read port and the DMA engine.

## Interface
- `ADDR_WIDTH`, 13: word address width of the ring (2^13 128-bit words); pointers are `ADDR_WIDTH+1` bits, MSB is the wrap bit.
- `BURST_WORDS`, 32: full burst length in 128-bit words; power of two, ≤ 2^ADDR_WIDTH.
- `TIMEOUT_CYCLES`, 1024: idle cycles with partial data before a short burst is forced.
- `IRQ_COALESCE`, 4: completed bursts per interrupt.
- `clock`  in  1  rd_clock of the RX buffer (DMA clock).
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  port enabled (enable_sfp && xcvr_ready).
- `rx_ring_wptr`  in  ADDR_WIDTH+1  write pointer, already clock-crossed by the buffer.
- `rd_address`  out  ADDR_WIDTH  buffer read address.
- `rdreq`  out  1  buffer read strobe.
- `dma_req`  out  1  burst request to the DMA engine.
- `dma_len`  out  $clog2(BURST_WORDS)+1  burst length in words; valid while `dma_req`.
- `dma_gnt`  in  1  single-cycle grant.
- `dma_ready`  in  1  sink guarantees to accept a word on the next cycle.
- `dma_valid`  out  1  buffer `data_out` valid this cycle.
- `dma_done`  out  1  one-cycle pulse at burst end.
- `rx_ring_rptr`  out  ADDR_WIDTH+1  current read pointer.
- `irq`  out  1  one-cycle interrupt pulse.
- `overflow`  out  1  sticky: writer lapped the reader.

## Operation
- `avail = rx_ring_wptr - rx_ring_rptr`, computed modulo 2^(ADDR_WIDTH+1).
- `avail > 2^ADDR_WIDTH` sets `overflow`. While `overflow` is set, no new burst starts.
- `enable` low while in IDLE: `rptr <= rx_ring_wptr` (data discarded), `overflow` cleared, timer cleared.
- FSM states: IDLE, REQ, XFER, DRAIN, DONE.
- IDLE → REQ when `enable && !overflow` and one of:
  - `avail >= BURST_WORDS`: `dma_len = BURST_WORDS`.
  - `avail > 0` and timer == TIMEOUT_CYCLES: `dma_len = avail`, and the burst is marked `short`.
- Full-burst check has priority over the timeout check.
- REQ: hold `dma_req` and `dma_len` stable until `dma_gnt`, then go to XFER with `cnt = dma_len`.
- XFER: each cycle `dma_ready` is high:
  - `rdreq = 1`, `rd_address = rptr[ADDR_WIDTH-1:0]`.
  - `rptr++` (wraps naturally through the MSB), `cnt--`.
  - Go to DRAIN after the cycle that issues the last word.
- DRAIN: one cycle, for the final `dma_valid`. Then DONE.
- DONE: pulse `dma_done`, increment burst counter. `irq` pulses when:
  - the counter reaches IRQ_COALESCE (counter then clears), or
  - the burst was `short` (counter also clears).
  - Return to IDLE.
- Timer: increments in IDLE while `0 < avail < BURST_WORDS`, saturating at TIMEOUT_CYCLES. Clears on leaving IDLE or when `avail == 0`.
- `enable` dropping in REQ/XFER/DRAIN: the burst completes normally, since the DMA engine is already committed. The `enable` IDLE rules apply afterwards.
- Overflow detected mid-burst: the burst completes; the flag blocks the next burst.

## Timing
- Reset values: `rd_address=0`, `rdreq=0`, `dma_req=0`, `dma_len=0`, `dma_valid=0`, `dma_done=0`, `rx_ring_rptr=0`, `irq=0`, `overflow=0`. FSM=IDLE, timer=0, burst counter=0.
- `dma_req` asserts the cycle after the IDLE condition is true.
- First `rdreq` may occur the cycle after `dma_gnt`.
- `dma_valid` is `rdreq` delayed by 1 cycle (RAM read latency 1).
- With `dma_ready` held high, a burst of N words takes N cycles in XFER, then DRAIN (1), then DONE (1). `dma_done` and `irq` occur in the same cycle.
- `dma_ready` low stalls `rdreq` with no loss; `cnt` and `rptr` hold.
- Timeout burst: `dma_req` rises TIMEOUT_CYCLES+1 cycles after `avail` first becomes non-zero, if `avail` stays below BURST_WORDS.

## Structure
- Shared package `sonic_rx_dma_pkg`: FSM state enum, pointer-width localparams, `avail` function.
- One natural sub-module: `sonic_irq_coalescer` (burst counter plus short-burst override; produces the `irq` pulse).

## Test plan
- Full burst: wptr 0→32 with `dma_gnt` 2 cycles after `dma_req` → `dma_len=32`; 32 `rdreq` at addresses 0..31; `dma_valid` lags by 1; `rptr=32`; `dma_done` pulses once; no `irq`.
- Coalescing: 4 consecutive full bursts (wptr=128) → exactly one `irq`, coincident with the 4th `dma_done`.
- Timeout: wptr=5, no further writes → `dma_req` with `dma_len=5` after 1025 cycles; `irq` on its `dma_done`.
- Wrap: rptr=0x1FF0, wptr=0x2010 → addresses 0x1FF0..0x1FFF then 0x0000..0x000F; rptr=0x2010.
- Backpressure and enable: `dma_ready` toggling 1/0 during a burst → 32 reads, no duplicates or skips. `enable` dropped mid-burst → burst completes, then rptr snaps to wptr.
- Overflow and reset: wptr−rptr=0x2001 → `overflow=1`, no `dma_req`; cleared by `enable` low. `reset_n` low mid-XFER → all outputs return to reset values immediately.
